// File: rtl/wrf_frame_gen.sv
// WR-fabric frame generator: emits back-to-back Ethernet frames of incrementing
// size and counting payload over a pipelined Wishbone master (16-bit data).
module wrf_frame_gen #(
    parameter int unsigned g_min_size   = 64,
    parameter int unsigned g_max_size   = 1500,
    parameter int unsigned g_gap_cycles = 16
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic [47:0] dst_mac_i,
    input  logic [47:0] src_mac_i,
    input  logic [15:0] ethertype_i,
    output logic        src_cyc_o,
    output logic        src_stb_o,
    output logic        src_we_o,
    output logic [1:0]  src_sel_o,
    output logic [1:0]  src_adr_o,
    output logic [15:0] src_dat_o,
    input  logic        src_ack_i,
    input  logic        src_stall_i,
    input  logic        src_err_i,
    output logic        busy_o,
    output logic [31:0] frame_cnt_o,
    output logic [31:0] err_cnt_o
);

    localparam int unsigned SZ_W  = 16;
    localparam int unsigned GAP_W = 16;
    localparam logic [SZ_W-1:0]  MIN_SZ   = SZ_W'(g_min_size);
    localparam logic [SZ_W-1:0]  MAX_SZ   = SZ_W'(g_max_size);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(g_gap_cycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STATUS,
        ST_HDR,
        ST_PAYLOAD,
        ST_WAIT_ACK,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [SZ_W-1:0]  size_q, size_d;
    logic [SZ_W-1:0]  next_size_q, next_size_d;
    logic [47:0]      dst_q, dst_d;
    logic [47:0]      src_q, src_d;
    logic [15:0]      etype_q, etype_d;
    logic [10:0]      idx_q, idx_d;
    logic [10:0]      outst_q, outst_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;
    logic [31:0]      err_cnt_q, err_cnt_d;

    logic             cyc;
    logic             stb;
    logic [1:0]       adr;
    logic [1:0]       sel;
    logic [15:0]      dat;
    logic             xfer;
    logic             ack_ok;
    logic             start;
    logic [SZ_W-1:0]  pay_len;
    logic [SZ_W-1:0]  pay_last;
    logic             pay_odd;
    logic             last_word;

    assign pay_len   = size_q - SZ_W'(14);
    assign pay_last  = (pay_len - SZ_W'(1)) >> 1;
    assign pay_odd   = pay_len[0];
    assign last_word = ({5'd0, idx_q} == pay_last);

    // State register
    always_ff @(posedge clk_sys or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            size_q      <= MIN_SZ;
            next_size_q <= MIN_SZ;
            dst_q       <= '0;
            src_q       <= '0;
            etype_q     <= '0;
            idx_q       <= '0;
            outst_q     <= '0;
            gap_q       <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            next_size_q <= next_size_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            etype_q     <= etype_d;
            idx_q       <= idx_d;
            outst_q     <= outst_d;
            gap_q       <= gap_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        next_size_d = next_size_q;
        dst_d       = dst_q;
        src_d       = src_q;
        etype_d     = etype_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        start       = 1'b0;

        xfer    = stb && !src_stall_i;
        // An ack landing with nothing outstanding is dropped unless it pairs with this cycle's transfer.
        ack_ok  = src_ack_i && ((outst_q != '0) || xfer);
        outst_d = outst_q + {10'd0, xfer} - {10'd0, ack_ok};

        unique case (state_q)
            ST_IDLE: start = enable_i;
            ST_STATUS: begin
                if (xfer) begin
                    state_d = ST_HDR;
                    idx_d   = '0;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    if (idx_q == 11'd6) begin
                        state_d = ST_PAYLOAD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 11'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    if (last_word) state_d = ST_WAIT_ACK;
                    else           idx_d   = idx_q + 11'd1;
                end
            end
            ST_WAIT_ACK: begin
                if (outst_d == '0) begin
                    state_d     = ST_GAP;
                    gap_d       = GAP_LOAD;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                end
            end
            ST_GAP: begin
                // The last gap cycle doubles as the IDLE decision so the cyc-low gap is exactly g_gap_cycles.
                if (gap_q == '0) begin
                    if (enable_i) start   = 1'b1;
                    else          state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cyc && src_err_i) begin
            state_d     = ST_GAP;
            gap_d       = GAP_LOAD;
            outst_d     = '0;
            frame_cnt_d = frame_cnt_q;
            err_cnt_d   = err_cnt_q + 32'd1;
        end

        if (start) begin
            state_d     = ST_STATUS;
            size_d      = next_size_q;
            next_size_d = (next_size_q == MAX_SZ) ? MIN_SZ : next_size_q + SZ_W'(1);
            dst_d       = dst_mac_i;
            src_d       = src_mac_i;
            etype_d     = ethertype_i;
            idx_d       = '0;
            outst_d     = '0;
        end
    end

    // Outputs; held by construction while stalled since idx only moves on a transfer
    always_comb begin
        cyc = 1'b0;
        stb = 1'b0;
        adr = '0;
        sel = '0;
        dat = '0;
        unique case (state_q)
            ST_STATUS: begin
                cyc = 1'b1;
                stb = 1'b1;
                adr = 2'd2;
                sel = 2'b11;
            end
            ST_HDR: begin
                cyc = 1'b1;
                stb = 1'b1;
                sel = 2'b11;
                case (idx_q[2:0])
                    3'd0:    dat = dst_q[47:32];
                    3'd1:    dat = dst_q[31:16];
                    3'd2:    dat = dst_q[15:0];
                    3'd3:    dat = src_q[47:32];
                    3'd4:    dat = src_q[31:16];
                    3'd5:    dat = src_q[15:0];
                    default: dat = etype_q;
                endcase
            end
            ST_PAYLOAD: begin
                cyc = 1'b1;
                stb = 1'b1;
                sel = 2'b11;
                dat = {idx_q[6:0], 1'b0, idx_q[6:0], 1'b1};
                if (last_word && pay_odd) begin
                    sel      = 2'b10;
                    dat[7:0] = 8'h00;
                end
            end
            ST_WAIT_ACK: cyc = 1'b1;
            default: ;
        endcase
    end

    assign src_cyc_o   = cyc;
    assign src_stb_o   = stb;
    assign src_we_o    = cyc;
    assign src_sel_o   = sel;
    assign src_adr_o   = adr;
    assign src_dat_o   = dat;
    assign busy_o      = (state_q != ST_IDLE);
    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_wrf_frame_gen.sv
// Randomized bench for wrf_frame_gen: a byte-stream frame model scores every
// transferred word, gap length, counters, stall hold and error/reset handling.
module tb_wrf_frame_gen;

    localparam int unsigned MIN_SZ = 64;
    localparam int unsigned MAX_SZ = 1500;
    localparam int unsigned GAP    = 16;
    localparam int unsigned MIN2   = 1499;
    localparam int unsigned MAX2   = 1500;
    localparam int unsigned GAP2   = 2;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Main DUT
    logic        rst_n;
    logic        enable_i;
    logic [47:0] dst_mac = 48'h112233445566;
    logic [47:0] src_mac = 48'h0A0B0C0D0E0F;
    logic [15:0] ethertype = 16'h88B5;
    logic        cyc, stb, we;
    logic [1:0]  sel, adr;
    logic [15:0] dat;
    logic        ack = 1'b0, stall = 1'b0, err = 1'b0;
    logic        busy;
    logic [31:0] frame_cnt, err_cnt;

    wrf_frame_gen #(.g_min_size(MIN_SZ), .g_max_size(MAX_SZ), .g_gap_cycles(GAP)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .enable_i(enable_i),
        .dst_mac_i(dst_mac), .src_mac_i(src_mac), .ethertype_i(ethertype),
        .src_cyc_o(cyc), .src_stb_o(stb), .src_we_o(we), .src_sel_o(sel),
        .src_adr_o(adr), .src_dat_o(dat), .src_ack_i(ack), .src_stall_i(stall),
        .src_err_i(err), .busy_o(busy), .frame_cnt_o(frame_cnt), .err_cnt_o(err_cnt)
    );

    // Size-wrap DUT
    logic        rst2;
    logic        en2;
    logic [47:0] dst2 = 48'hA1A2A3A4A5A6;
    logic [47:0] src2 = 48'hB1B2B3B4B5B6;
    logic [15:0] et2 = 16'h0800;
    logic        cyc2, stb2, we2;
    logic [1:0]  sel2, adr2;
    logic [15:0] dat2;
    logic        ack2 = 1'b0;
    logic        stall2 = 1'b0;
    logic        err2 = 1'b0;
    logic        busy2;
    logic [31:0] frame_cnt2, err_cnt2;

    wrf_frame_gen #(.g_min_size(MIN2), .g_max_size(MAX2), .g_gap_cycles(GAP2)) dut2 (
        .clk_sys(clk_sys), .rst_n(rst2), .enable_i(en2),
        .dst_mac_i(dst2), .src_mac_i(src2), .ethertype_i(et2),
        .src_cyc_o(cyc2), .src_stb_o(stb2), .src_we_o(we2), .src_sel_o(sel2),
        .src_adr_o(adr2), .src_dat_o(dat2), .src_ack_i(ack2), .src_stall_i(stall2),
        .src_err_i(err2), .busy_o(busy2), .frame_cnt_o(frame_cnt2), .err_cnt_o(err_cnt2)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a frame is a byte stream (14 header bytes then k mod 256), sent
    // as one status word plus big-endian byte pairs, padding the odd tail.
    function automatic logic [7:0] frame_byte(input logic [111:0] hdr, input int unsigned k);
        if (k < 14) return hdr[111 - 8*k -: 8];
        return 8'((k - 14) % 256);
    endfunction

    function automatic int unsigned n_words(input int unsigned len);
        return 1 + (len + 1) / 2;
    endfunction

    function automatic logic [19:0] exp_word(input int unsigned len, input logic [111:0] hdr,
                                             input int unsigned i);
        int unsigned b;
        logic        has_lo;
        if (i == 0) return {2'd2, 2'b11, 16'h0000};
        b      = 2 * (i - 1);
        has_lo = (b + 1 < len);
        return {2'd0, 1'b1, has_lo, frame_byte(hdr, b), has_lo ? frame_byte(hdr, b + 1) : 8'h00};
    endfunction

    // Knobs owned by the main sequence
    bit          stall_rand = 0, ack_rand = 0, ack_lat0 = 0, mac_rand = 0;
    int unsigned err_req = 0;

    // Model state owned by the monitor
    int unsigned exp_L, exp_frames, exp_errs, widx, owed, ack_n, gap_len;
    int unsigned frames_seen = 0;
    int unsigned err_done = 0;
    logic [111:0] cur_hdr;
    logic        in_frame = 1'b0, aborted, gap_valid, xfer;
    logic        prev_cyc, prev_stb, prev_stall, prev_err;
    logic [19:0] prev_word;

    always @(negedge clk_sys) begin
        if (rst_n) begin
            chk("reset_outs", {cyc, stb, we, sel, adr, dat, busy}, '0);
            chk("reset_cnts", {frame_cnt, err_cnt}, '0);
            stall = 1'b0; ack = 1'b0; err = 1'b0;
            exp_L = MIN_SZ; exp_frames = 0; exp_errs = 0; owed = 0;
            in_frame = 1'b0; aborted = 1'b0; gap_valid = 1'b0;
            prev_cyc = 1'b0; prev_stb = 1'b0; prev_stall = 1'b0; prev_err = 1'b0;
        end else begin
            if (prev_err) chk("err_drop_cyc", cyc, 1'b0);
            if (cyc && !prev_cyc) begin
                if (gap_valid) chk("gap_len", gap_len, GAP);
                cur_hdr  = {dst_mac, src_mac, ethertype};
                widx     = 0; ack_n = 0; aborted = 1'b0; in_frame = 1'b1;
                if (mac_rand) begin
                    dst_mac   = {16'($urandom), $urandom};
                    src_mac   = {16'($urandom), $urandom};
                    ethertype = 16'($urandom);
                end
            end
            if (!cyc && prev_cyc) begin
                if (aborted) begin
                    exp_errs++;
                    chk("err_cnt", err_cnt, exp_errs);
                    chk("frame_cnt_on_err", frame_cnt, exp_frames);
                end else begin
                    chk("word_count", widx, n_words(exp_L));
                    chk("acks_done", owed, 0);
                    exp_frames++;
                    chk("frame_cnt", frame_cnt, exp_frames);
                end
                exp_L     = (exp_L == MAX_SZ) ? MIN_SZ : exp_L + 1;
                in_frame  = 1'b0; gap_valid = 1'b1; gap_len = 0;
                frames_seen++;
            end
            if (!cyc) begin
                gap_len++;
                if (!enable_i) gap_valid = 1'b0;
            end
            chk("we_eq_cyc", we, cyc);
            if (cyc) chk("busy_in_frame", busy, 1'b1);
            if (prev_stb && prev_stall && cyc && !prev_err)
                chk("stall_hold", {stb, adr, sel, dat}, {1'b1, prev_word});

            stall = stall_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
            xfer  = stb && !stall;
            if (xfer && in_frame && !aborted) begin
                chk("word", {adr, sel, dat}, exp_word(exp_L, cur_hdr, widx));
                widx++;
            end
            if (xfer && ack_lat0) owed++;
            ack = (owed > 0) && (!ack_rand || $urandom_range(0, 3) != 0);
            if (ack) begin
                owed--;
                ack_n++;
            end
            if (xfer && !ack_lat0) owed++;
            err = 1'b0;
            if (ack && in_frame && !aborted && err_req != err_done && ack_n == 10) begin
                err = 1'b1; aborted = 1'b1; owed = 0; err_done = err_req;
            end
            prev_err = err; prev_cyc = cyc; prev_stb = stb; prev_stall = stall;
            prev_word = {adr, sel, dat};
        end
    end

    // Size-wrap monitor: zero-latency acks, no stall
    int unsigned d2_frames = 0, d2_words = 0, d2_L = MIN2;
    logic [19:0] d2_last;
    logic        d2_prev_cyc = 1'b0;

    always @(negedge clk_sys) begin
        ack2 = 1'b0;
        if (!rst2) begin
            if (stb2) begin
                d2_words++;
                d2_last = {adr2, sel2, dat2};
                ack2    = 1'b1;
            end
            if (!cyc2 && d2_prev_cyc && d2_frames < 3) begin
                chk("d2_words", d2_words, n_words(d2_L));
                chk("d2_last_word", d2_last, exp_word(d2_L, {dst2, src2, et2}, n_words(d2_L) - 1));
                d2_frames++;
                d2_L = (d2_L == MAX2) ? MIN2 : d2_L + 1;
            end
            if (!cyc2) d2_words = 0;
            d2_prev_cyc = cyc2;
        end
    end

    task automatic wait_frames(input int unsigned n, input string tag);
        int unsigned target = frames_seen + n;
        int unsigned cnt    = 0;
        while (frames_seen < target && cnt < 20000) begin
            @(posedge clk_sys);
            cnt++;
        end
        chk(tag, frames_seen >= target, 1'b1);
        #2;
    endtask

    task automatic wait_in_frame(input int unsigned min_w, input string tag);
        int unsigned cnt = 0;
        while (!(in_frame && widx >= min_w) && cnt < 5000) begin
            @(posedge clk_sys);
            cnt++;
        end
        chk(tag, in_frame, 1'b1);
        #2;
    endtask

    initial begin
        int unsigned seen, cnt;
        rst_n = 1'b1; rst2 = 1'b1; enable_i = 1'b0; en2 = 1'b0;
        repeat (4) @(posedge clk_sys);
        #2 rst_n = 1'b0; rst2 = 1'b0; en2 = 1'b1;
        @(posedge clk_sys); #2;
        chk("idle_after_reset", {cyc, busy}, '0);
        enable_i = 1'b1;

        // Sizes 64 and 65, ack one cycle after strobe
        wait_frames(2, "timeout_basic");

        // Random stall and ack spacing, changing MACs between frames
        stall_rand = 1; ack_rand = 1; mac_rand = 1;
        wait_frames(4, "timeout_stall");
        ack_lat0 = 1;
        wait_frames(3, "timeout_lat0");

        // Error on the 10th ack, then a normal frame of the following size
        err_req = err_req + 1;
        wait_frames(2, "timeout_err");

        // Enable dropped mid-frame: frame finishes, block then stays idle
        wait_in_frame(3, "timeout_mid_frame");
        enable_i = 1'b0;
        wait_frames(1, "timeout_disable");
        seen = frames_seen;
        repeat (GAP + 20) @(posedge clk_sys);
        #2;
        chk("idle_no_frame", frames_seen, seen);
        chk("idle_quiet", {cyc, busy}, '0);

        // Reset asserted mid-payload for 2 cycles
        enable_i = 1'b1;
        wait_in_frame(12, "timeout_payload");
        rst_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        #2 rst_n = 1'b0;
        wait_frames(2, "timeout_after_reset");

        cnt = 0;
        while (d2_frames < 3 && cnt < 10000) begin
            @(posedge clk_sys);
            cnt++;
        end
        chk("timeout_wrap", d2_frames, 3);
        #2;
        chk("d2_frame_cnt", frame_cnt2 >= 32'd3, 1'b1);
        chk("d2_err_cnt", err_cnt2, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wrf_frame_gen.md
Name: wrf_frame_gen

Overview:
- WR-fabric frame generator that drives the sink side of the fabric loopback stage, directly upstream of it.
- Emits back-to-back Ethernet frames of deterministic, incrementing size and content so that the downstream loopback and its sink checker can verify size sequence, MAC rewrite and payload integrity.
- The fabric interface is a pipelined Wishbone master with 16-bit data and a 2-bit address.
- The block exposes frame/error counters for bench and software readout.

Parameters:
- g_min_size, 64, first and minimum frame length in bytes (header + payload, no FCS); must be ≥ 15.
- g_max_size, 1500, maximum frame length in bytes; after a frame of this size the next size wraps to g_min_size.
- g_gap_cycles, 16, idle cycles with cyc low between frames (≥ 1).

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-high
- enable_i  in  1  level; generate frames while high
- dst_mac_i  in  48  destination MAC, sampled at frame start
- src_mac_i  in  48  source MAC, sampled at frame start
- ethertype_i  in  16  ethertype, sampled at frame start
- src_cyc_o  out  1  fabric cycle
- src_stb_o  out  1  fabric strobe
- src_we_o  out  1  always 1 while cyc high, else 0
- src_sel_o  out  2  byte selects
- src_adr_o  out  2  fabric address (2 = status, 0 = data)
- src_dat_o  out  16  fabric data
- src_ack_i  in  1  word acknowledged
- src_stall_i  in  1  sink stall
- src_err_i  in  1  sink error
- busy_o  out  1  high from frame start until end of the following gap
- frame_cnt_o  out  32  frames completed without error
- err_cnt_o  out  32  frames aborted by src_err_i

Behaviour:
- Reset
  - All outputs are 0 on reset.
  - Internal next-size register = g_min_size.
  - Reset asserted mid-frame drops cyc/stb immediately; the partial frame is neither counted nor resumed.
- Handshake
  - A word is transferred when stb=1 and stall=0.
  - stb, adr, dat and sel are held unchanged while stall=1.
  - cyc stays high until the number of acks equals the number of words transferred.
  - Outstanding-ack counter is 11 bits wide; an ack with zero outstanding is ignored.
- FSM states: IDLE, STATUS, HDR, PAYLOAD, WAIT_ACK, GAP.
  - IDLE: when enable_i=1, latch MACs, ethertype and size L, then go to STATUS. cyc and stb rise on the next clock edge.
  - STATUS: one word, adr=2, dat=0x0000, sel=11.
  - HDR: 7 words, adr=0, sel=11, big-endian. Order is dst[47:32], dst[31:16], dst[15:0], src[47:32], src[31:16], src[15:0], ethertype.
  - PAYLOAD: P = L−14 bytes. Payload byte k (0-based) = k mod 256.
    - Each word carries bytes 2i and 2i+1, with the even byte in dat[15:8].
    - If P is odd, the last word has sel=10 and dat[7:0]=0x00.
    - Word count = ceil(P/2).
  - WAIT_ACK: stb=0 and cyc=1 until all acks have arrived. Then cyc=0, frame_cnt_o increments by 1 (wrapping at 2^32), and the FSM goes to GAP.
  - GAP: cyc=0 for g_gap_cycles cycles, then IDLE.
- Size sequence
  - After each completed or aborted frame, next size = L+1.
  - If L = g_max_size, next size = g_min_size.
- src_err_i (any state with cyc=1)
  - Next cycle: stb=0, cyc=0, outstanding counter cleared, err_cnt_o increments by 1, FSM goes to GAP.
  - frame_cnt_o is not incremented.
  - err_i and the final ack arriving in the same cycle are treated as an error.
- enable_i deasserted mid-frame: the current frame completes normally, including its gap; the FSM then remains in IDLE.
- Zero-latency ack is allowed: an ack in the same cycle as a transfer is counted correctly.
- busy_o = (state ≠ IDLE).

Test Plan:
- enable=1, stall=0, ack one cycle after each strobe, g_min_size=64 → first frame has 1 status + 7 header + 25 payload words = 33 strobes; payload words are 0x0001, 0x0203 … 0x3031; frame_cnt=1 after cyc falls.
- Same setup with 2 frames → second frame L=65 has a last word 0x3200 with sel=10; the gap between the two frames is exactly 16 cycles with cyc=0.
- dst_mac=0x112233445566, stall asserted pseudo-randomly 50% of cycles → received byte stream matches the no-stall case exactly; no word is duplicated or dropped.
- g_min_size=1499, g_max_size=1500, 3 frames → sizes are 1499, 1500, 1499.
- Pulse src_err_i on the 10th ack → cyc low next cycle, err_cnt=1, frame_cnt unchanged; the next frame has size L+1 and starts after the gap.
- Assert rst_n mid-payload for 2 cycles, then release with enable=1 → all outputs 0 during reset; first frame after reset has size g_min_size and counters are 0.
